// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types for the fetch PC sequencer: virtual address, redirect priority and request record.
package fetch_redirect_ctrl_pkg;

   typedef logic [31:0] virt_t;

   // Numeric order matters: a larger value is the more urgent redirect.
   typedef enum logic [1:0] {
      PRIO_NONE = 2'd0,
      PRIO_PRED = 2'd1,
      PRIO_RES  = 2'd2,
      PRIO_EXC  = 2'd3
   } redirect_prio_t;

   typedef struct packed {
      logic           valid;
      redirect_prio_t prio;
      virt_t          target;
   } redirect_req_t;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_redirect_ctrl_prio_mux.sv
// Combinational priority select of this cycle's redirect requests against the held one.
// A new request beats the held entry when its priority is equal or higher; win_new tells which side won.
module redirect_prio_mux
   import fetch_redirect_ctrl_pkg::*;
(
   input  redirect_req_t exc,
   input  redirect_req_t res,
   input  redirect_req_t pred,
   input  redirect_req_t pend,
   output redirect_req_t win,
   output logic          win_new
);

   redirect_req_t newest;

   always_comb begin
      newest = '0;
      if (exc.valid)
         newest = exc;
      else if (res.valid)
         newest = res;
      else if (pred.valid)
         newest = pred;

      win     = pend;
      win_new = 1'b0;
      if (newest.valid && (!pend.valid || newest.prio >= pend.prio)) begin
         win     = newest;
         win_new = 1'b1;
      end
   end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: picks the next icache address from redirects or the sequential step,
// and holds a redirect across icache-busy / backend-stall cycles so none is lost.
module fetch_redirect_ctrl
   import fetch_redirect_ctrl_pkg::*;
#(
   parameter virt_t BOOT_VEC = 32'hbfc00000,
   parameter int    N_ISSUE  = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ready,
   input  logic        stall,
   input  logic        except_valid,
   input  logic [31:0] except_target,
   input  logic        resolve_valid,
   input  logic [31:0] resolve_target,
   input  logic        predict_valid,
   input  logic [31:0] predict_target,
   output logic [31:0] pc,
   output logic [31:0] npc,
   output logic        flush,
   output logic        redirect_pend
);

   localparam virt_t STEP = virt_t'(4 * N_ISSUE);

   fetch_state_t  state;
   redirect_req_t pend;
   redirect_req_t exc_req, res_req, pred_req, win;
   logic          win_new;
   logic          running;
   logic          win_vld;
   logic          advance;
   logic          pred_ok;

   // A prediction is stale once a mispredict/exception is pending or arriving.
   assign pred_ok = predict_valid && !except_valid && !resolve_valid &&
                    !(pend.valid && pend.prio >= PRIO_RES);

   assign exc_req  = '{valid: except_valid,  prio: PRIO_EXC,  target: except_target};
   assign res_req  = '{valid: resolve_valid, prio: PRIO_RES,  target: resolve_target};
   assign pred_req = '{valid: pred_ok,       prio: PRIO_PRED, target: predict_target};

   redirect_prio_mux u_mux (
      .exc     (exc_req),
      .res     (res_req),
      .pred    (pred_req),
      .pend    (pend),
      .win     (win),
      .win_new (win_new)
   );

   // Redirects are not honoured until the boot fetch has been accepted.
   assign running = !rst && (state != ST_BOOT);
   assign win_vld = running && win.valid;
   assign advance = ready && !stall;

   assign flush = win_vld && win_new && (win.prio >= PRIO_RES);

   always_comb begin
      if (!running)
         npc = BOOT_VEC;
      else if (win_vld)
         npc = win.target;
      else
         npc = pc + STEP;
   end

   assign redirect_pend = (state == ST_HOLD);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_BOOT;
         pc    <= BOOT_VEC - STEP;
         pend  <= '0;
      end else begin
         case (state)
            ST_BOOT: begin
               if (advance) begin
                  pc    <= npc;
                  state <= ST_RUN;
               end
            end
            ST_RUN, ST_HOLD: begin
               if (advance) begin
                  pc         <= npc;
                  pend.valid <= 1'b0;
                  pend.prio  <= PRIO_NONE;
                  state      <= ST_RUN;
               end else if (win_vld) begin
                  pend  <= '{valid: 1'b1, prio: win.prio, target: win.target};
                  state <= ST_HOLD;
               end
            end
            default: begin
               state <= ST_BOOT;
               pend  <= '0;
            end
         endcase
      end
   end

endmodule
